// File: rtl/wb_stage_q.sv
// wb_stage_q: writeback stage. Priority-selects one of NSRC result sources,
// buffers {wen, rd, data} in a DEPTH-entry FIFO and drains one regfile write
// per granted cycle, counting every retired entry.
// Optional macro WB_FWD_EN adds a youngest-match forwarding lookup into the FIFO.
module wb_stage_q #(
  parameter int XLEN  = 64,
  parameter int NSRC  = 3,
  parameter int DEPTH = 2,
  parameter int CNT_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NSRC-1:0]      in_wen,
  input  logic [NSRC*XLEN-1:0] in_wdata,
  input  logic [4:0]           in_rd,
  input  logic                 rf_ready,
  output logic                 wen_o,
  output logic [4:0]           waddr_o,
  output logic [XLEN-1:0]      wdata_o,
  output logic                 retire_o,
  output logic [CNT_W-1:0]     retire_cnt_o,
  output logic                 multi_hit_o
`ifdef WB_FWD_EN
  ,
  input  logic [4:0]           fwd_rs,
  output logic                 fwd_hit,
  output logic [XLEN-1:0]      fwd_data
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic            wen;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          push_e, head;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic            multi_hit_q, multi_hit_d;
  logic            empty, full, push, pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign count    = wr_ptr_q - rd_ptr_q;
  // in_ready is held low while reset is asserted so nothing looks acceptable
  assign in_ready = rst && !full;
  assign push     = in_valid && in_ready && !flush;
  assign pop      = !empty && rf_ready && !flush;
  assign head     = mem_q[rd_ptr_q[AW-1:0]];

  // Build the pushed entry: lowest-index asserted source wins, no-write entries carry zero data
  always_comb begin
    push_e = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (in_wen[i]) push_e.data = in_wdata[i*XLEN +: XLEN];
    end
    push_e.rd  = in_rd;
    push_e.wen = (|in_wen) && (in_rd != 5'd0);
    if (!push_e.wen) push_e.data = '0;
  end

  // Next-state for pointers, retire counter and sticky multi-source flag
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    retire_cnt_d = retire_cnt_q + CNT_W'(pop);
    multi_hit_d  = multi_hit_q || (push && ((in_wen & (in_wen - NSRC'(1))) != '0));
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Control state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      retire_cnt_q <= '0;
      multi_hit_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      retire_cnt_q <= retire_cnt_d;
      multi_hit_q  <= multi_hit_d;
    end
  end

  // FIFO storage; cleared on reset so no stale data is ever visible
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_e;
    end
  end

  // Write port driven straight from the head register; flush suppresses it
  assign wen_o        = head.wen && !empty && !flush;
  assign waddr_o      = wen_o ? head.rd : 5'd0;
  assign wdata_o      = wen_o ? head.data : '0;
  assign retire_o     = pop;
  assign retire_cnt_o = retire_cnt_q;
  assign multi_hit_o  = multi_hit_q;

`ifdef WB_FWD_EN
  logic [PW-1:0] fwd_idx;
  // Scan oldest to youngest so the last (youngest) match overrides earlier ones
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = rd_ptr_q + PW'(k);
      if ((PW'(k) < count) && mem_q[fwd_idx[AW-1:0]].wen &&
          (mem_q[fwd_idx[AW-1:0]].rd == fwd_rs) && (fwd_rs != 5'd0)) begin
        fwd_hit  = 1'b1;
        fwd_data = mem_q[fwd_idx[AW-1:0]].data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage_q.sv
// tb_wb_stage_q: directed scenarios plus random traffic against a queue model
// of the writeback stage, with a per-cycle compare process.
module tb_wb_stage_q;
  localparam int XLEN = 64, NSRC = 3, DEPTH = 2, CNT_W = 64;

  logic              clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, rf_ready = 1'b0;
  logic [NSRC-1:0]   in_wen = '0;
  logic [NSRC*XLEN-1:0] in_wdata = '0;
  logic [4:0]        in_rd = '0, waddr_o;
  logic              in_ready, wen_o, retire_o, multi_hit_o;
  logic [XLEN-1:0]   wdata_o;
  logic [CNT_W-1:0]  retire_cnt_o;
`ifdef WB_FWD_EN
  logic [4:0]        fwd_rs = '0;
  logic              fwd_hit;
  logic [XLEN-1:0]   fwd_data;
`endif

  wb_stage_q #(.XLEN(XLEN), .NSRC(NSRC), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_wen(in_wen), .in_wdata(in_wdata), .in_rd(in_rd), .rf_ready(rf_ready),
    .wen_o(wen_o), .waddr_o(waddr_o), .wdata_o(wdata_o), .retire_o(retire_o),
    .retire_cnt_o(retire_cnt_o), .multi_hit_o(multi_hit_o)
`ifdef WB_FWD_EN
    , .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         wen;
    logic [4:0] rd;
    logic [63:0] data;
  } m_t;

  m_t          q[$];
  logic [63:0] m_cnt = '0;
  bit          m_multi = 1'b0;
  int          errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance one clock, updating the model from the inputs seen before the edge
  task automatic cycle();
    bit  do_push, do_pop, mh;
    m_t  e;
    do_pop  = rst && q.size() > 0 && rf_ready && !flush;
    do_push = rst && in_valid && q.size() < DEPTH && !flush;
    mh      = do_push && ($countones(in_wen) > 1);
    e.wen   = (in_wen != '0) && (in_rd != 5'd0);
    e.rd    = in_rd;
    e.data  = '0;
    if (e.wen) begin
      for (int i = NSRC - 1; i >= 0; i--)
        if (in_wen[i]) e.data = in_wdata[i*XLEN +: XLEN];
    end
    @(posedge clk);
    if (rst) begin
      if (flush) q.delete();
      else begin
        if (do_pop) begin void'(q.pop_front()); m_cnt++; end
        if (do_push) q.push_back(e);
      end
      if (mh) m_multi = 1'b1;
    end
    #1;
  endtask

  task automatic set_in(input bit v, input logic [2:0] w, input logic [4:0] rd,
                        input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2,
                        input bit rfr, input bit fl);
    in_valid = v; in_wen = w; in_rd = rd; in_wdata = {d2, d1, d0};
    rf_ready = rfr; flush = fl;
  endtask

  // Every cycle out of reset, DUT outputs must match what the queue model implies
  always @(negedge clk) begin
    if (rst) begin
      bit exp_wen;
      exp_wen = q.size() > 0 && q[0].wen && !flush;
      chk("in_ready", in_ready, q.size() < DEPTH);
      chk("wen_o", wen_o, exp_wen);
      chk("waddr_o", waddr_o, exp_wen ? q[0].rd : 5'd0);
      chk("wdata_o", wdata_o, exp_wen ? q[0].data : 64'd0);
      chk("retire_o", retire_o, q.size() > 0 && rf_ready && !flush);
      chk("retire_cnt_o", retire_cnt_o, m_cnt);
      chk("multi_hit_o", multi_hit_o, m_multi);
`ifdef WB_FWD_EN
      begin
        bit h; logic [63:0] d;
        h = 1'b0; d = '0;
        if (fwd_rs != 5'd0)
          for (int k = q.size() - 1; k >= 0 && !h; k--)
            if (q[k].wen && q[k].rd == fwd_rs) begin h = 1'b1; d = q[k].data; end
        chk("fwd_hit", fwd_hit, h);
        chk("fwd_data", fwd_data, d);
      end
`endif
    end
  end

  initial begin
    // Reset state
    #2;
    chk("rst wen_o", wen_o, 0);
    chk("rst in_ready", in_ready, 0);
    chk("rst cnt", retire_cnt_o, 0);
    chk("rst multi", multi_hit_o, 0);
    @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("post-rst in_ready", in_ready, 1);

    // Priority select and multi-hit
    set_in(1, 3'b110, 5'd5, 64'h0, 64'h11, 64'h22, 1, 0);
    cycle();
    set_in(0, 3'b000, 5'd0, 0, 0, 0, 1, 0);
    chk("t1 wen_o", wen_o, 1);
    chk("t1 waddr_o", waddr_o, 5);
    chk("t1 wdata_o", wdata_o, 64'h11);
    chk("t1 multi", multi_hit_o, 1);
    cycle();
    chk("t1 cnt", retire_cnt_o, 1);

    // Full FIFO back-pressure and in-order drain
    set_in(1, 3'b001, 5'd1, 64'hA1, 0, 0, 0, 0); cycle();
    set_in(1, 3'b001, 5'd2, 64'hB2, 0, 0, 0, 0); cycle();
    chk("t2 full in_ready", in_ready, 0);
    set_in(1, 3'b001, 5'd3, 64'hC3, 0, 0, 0, 0); #1;
    chk("t2 head waddr", waddr_o, 1);
    rf_ready = 1'b1; cycle();
    chk("t2 second waddr", waddr_o, 2);
    cycle();
    chk("t2 third waddr", waddr_o, 3);
    chk("t2 third data", wdata_o, 64'hC3);
    in_valid = 1'b0; cycle();
    chk("t2 cnt", retire_cnt_o, 4);
    chk("t2 empty wen", wen_o, 0);

    // rd==0 retires without a write
    set_in(1, 3'b001, 5'd0, 64'hFF, 0, 0, 1, 0); cycle();
    in_valid = 1'b0; #1;
    chk("t3 wen_o", wen_o, 0);
    chk("t3 wdata_o", wdata_o, 0);
    chk("t3 retire_o", retire_o, 1);
    cycle();
    chk("t3 cnt", retire_cnt_o, 5);

    // Flush with two buffered entries and an incoming one
    set_in(1, 3'b010, 5'd4, 0, 64'h44, 0, 0, 0); cycle();
    set_in(1, 3'b010, 5'd5, 0, 64'h55, 0, 0, 0); cycle();
    chk("t4 pre wen", wen_o, 1);
    set_in(1, 3'b001, 5'd6, 64'h66, 0, 0, 1, 1); #1;
    chk("t4 flush wen", wen_o, 0);
    chk("t4 flush retire", retire_o, 0);
    cycle();
    set_in(0, 3'b000, 5'd0, 0, 0, 0, 1, 0);
    chk("t4 post in_ready", in_ready, 1);
    chk("t4 post wen", wen_o, 0);
    cycle(); cycle();
    chk("t4 cnt", retire_cnt_o, 5);

`ifdef WB_FWD_EN
    // Forwarding: youngest match wins, x0 never hits
    set_in(1, 3'b001, 5'd7, 64'hA, 0, 0, 0, 0); cycle();
    set_in(1, 3'b001, 5'd7, 64'hB, 0, 0, 0, 0); cycle();
    in_valid = 1'b0; fwd_rs = 5'd7; #1;
    chk("t5 fwd_hit", fwd_hit, 1);
    chk("t5 fwd_data", fwd_data, 64'hB);
    fwd_rs = 5'd0; #1;
    chk("t5 x0 hit", fwd_hit, 0);
    chk("t5 x0 data", fwd_data, 0);
    flush = 1'b1; cycle(); flush = 1'b0;
`endif

    // Async reset mid-drain with a full FIFO
    set_in(1, 3'b100, 5'd9, 0, 0, 64'h99, 0, 0); cycle();
    set_in(1, 3'b100, 5'd10, 0, 0, 64'hAA, 0, 0); cycle();
    set_in(0, 3'b000, 5'd0, 0, 0, 0, 1, 0); #1;
    chk("t6 pre wen", wen_o, 1);
    rst = 1'b0;
    q.delete(); m_cnt = '0; m_multi = 1'b0; #1;
    chk("t6 rst wen", wen_o, 0);
    chk("t6 rst cnt", retire_cnt_o, 0);
    chk("t6 rst multi", multi_hit_o, 0);
    chk("t6 rst retire", retire_o, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("t6 in_ready", in_ready, 1);
    cycle();
    chk("t6 no write", wen_o, 0);

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      set_in($urandom_range(0, 9) < 7, 3'($urandom), rd,
             {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
`ifdef WB_FWD_EN
      fwd_rs = 5'($urandom_range(0, 31));
`endif
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/wb_stage_q.md
Name: wb_stage_q

Overview:
- Parametrised next-generation writeback stage.
- Accepts one retiring instruction per cycle from NSRC result sources (e.g. CSR, MEM, EX) via valid/ready.
- Resolves source priority, then buffers the result in a DEPTH-entry FIFO.
- Drains one register-file write per cycle when the shared regfile write port grants (rf_ready). Counts retired instructions.

Parameters:
- XLEN, 64, data width of each source and of the write port.
- NSRC, 3, number of write sources; index 0 is highest priority.
- DEPTH, 2, FIFO entries; power of two, >=2.
- CNT_W, 64, width of retire counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  discard all buffered and incoming entries.
- in_valid  in  1  upstream has a retiring instruction.
- in_ready  out  1  stage can accept (= !full).
- in_wen  in  NSRC  per-source write request.
- in_wdata  in  NSRC*XLEN  per-source data; source i at bits [i*XLEN +: XLEN].
- in_rd  in  5  destination register.
- rf_ready  in  1  regfile write port granted this cycle.
- wen_o  out  1  regfile write enable.
- waddr_o  out  5  regfile write address.
- wdata_o  out  XLEN  regfile write data.
- retire_o  out  1  one entry popped this cycle (write or no-write).
- retire_cnt_o  out  CNT_W  total popped entries.
- multi_hit_o  out  1  sticky: more than one in_wen bit set on an accepted push.

Behaviour:
- Reset (rst=0, async): FIFO empty, pointers 0, retire_cnt_o=0, multi_hit_o=0.
  - All outputs 0 during reset, except in_ready=1 once rst deasserts.
- Push when in_valid && in_ready && !flush. Entry = {wen, rd, data}:
  - sel = lowest index i with in_wen[i]=1; data = that source's slice.
  - wen = |in_wen && in_rd!=0.
  - If no in_wen bit is set, or rd==0: entry still enqueued with wen=0 and data=0, so it retires without a write.
- Pop when FIFO non-empty && rf_ready && !flush.
  - wen_o = head.wen && !empty. waddr_o and wdata_o come from the head when wen_o=1, else 0.
  - Outputs are combinational from the head register; no combinational path from in_* to wen_o.
- Latency: push at edge N, earliest write visible in cycle N+1. No empty-bypass.
- Throughput: 1 push and 1 pop per cycle. Simultaneous push+pop keeps the count unchanged.
  - in_ready = !full. A push in a full cycle is not accepted, even if a pop occurs that cycle.
- Pointers: log2(DEPTH)+1 bits with wrap bit. Full when indices are equal and wrap bits differ; empty when pointers are equal.
- retire_o = pop this cycle. retire_cnt_o increments by 1 per pop and wraps modulo 2^CNT_W.
- flush:
  - At the next edge, pointers reset and the FIFO becomes empty.
  - No push or pop in a flush cycle. wen_o and retire_o are forced 0 during that cycle.
  - retire_cnt_o and multi_hit_o are unaffected.
- multi_hit_o: set at the edge of an accepted push with popcount(in_wen)>1. Cleared only by reset.
- Reset mid-operation discards buffered entries immediately; no partial writes afterward.

Optional Feature:
- Macro WB_FWD_EN adds forwarding lookup ports:
  - fwd_rs (in, 5).
  - fwd_hit (out, 1).
  - fwd_data (out, XLEN).
- With WB_FWD_EN: combinational search of valid FIFO entries with wen=1 and rd==fwd_rs.
  - Youngest match wins.
  - fwd_rs==0 never hits.
  - Returns 0 when there is no hit.
  - Flush-cycle lookups still see the current contents.
- Without WB_FWD_EN: ports absent; no search logic.

Test Plan:
- Reset, then push in_wen=3'b110, rd=5, source1 data=0x11, source2 data=0x22, rf_ready=1 -> next cycle wen_o=1, waddr_o=5, wdata_o=0x11, retire_cnt_o=1, multi_hit_o=1.
- DEPTH=2, rf_ready=0, three pushes -> in_ready=0 after the second. Raise rf_ready -> pops in order, the third push is accepted one cycle after the first pop, retire_cnt_o=3.
- Push rd=0 with in_wen=3'b001, data=0xFF -> wen_o=0, wdata_o=0, retire_o=1.
- FIFO holds two entries, assert flush with in_valid=1 -> after the edge FIFO is empty, no write ever issues, retire_cnt_o unchanged.
- With WB_FWD_EN: buffer rd=7 data=0xA then rd=7 data=0xB, fwd_rs=7 -> fwd_hit=1, fwd_data=0xB; fwd_rs=0 -> fwd_hit=0.
- Assert rst low asynchronously mid-drain with DEPTH entries buffered -> wen_o drops immediately, retire_cnt_o=0, in_ready=1 after release.
